// File: rtl/exu_oitf_param.sv
// Outstanding-instruction-track FIFO for long-pipe EXU instructions.
// Latency: allocate/retire take effect at the next edge; hazard, retire and status outputs are combinational from state.
// Backpressure: dis_ready drops while all entries are valid; a slot freed by a retire is offered the following cycle.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   dis_*, disp_i_*       dispatch allocation request and the dispatched instruction's register usage
//   oitfrd_match_*        RAW (rs1/rs2) and WAW (rd) hazards against outstanding entries
//   ret_*                 oldest entry (pointer, rd info, PC) and its retire strobe
//   flush                 discard every entry
//   oitf_empty/full/count occupancy
module exu_oitf_param #(
  parameter int OITF_DEPTH  = 4,
  parameter int RFIDX_WIDTH = 5,
  parameter int PC_SIZE     = 32,
  localparam int PTR_W      = (OITF_DEPTH > 1) ? $clog2(OITF_DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dis_ena,
  output logic                   dis_ready,
  input  logic                   disp_i_rdwen,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
  input  logic [PC_SIZE-1:0]     disp_i_pc,
  input  logic                   disp_i_rs1en,
  input  logic                   disp_i_rs2en,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprd,
  output logic [PTR_W-1:0]       dis_ptr,
  input  logic                   ret_ena,
  output logic [PTR_W-1:0]       ret_ptr,
  output logic                   ret_rdwen,
  output logic [RFIDX_WIDTH-1:0] ret_rdidx,
  output logic [PC_SIZE-1:0]     ret_pc,
  input  logic                   flush,
  output logic                   oitf_empty,
  output logic                   oitf_full,
  output logic [PTR_W:0]         oitf_count
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(OITF_DEPTH - 1);

  logic [PTR_W-1:0]       alc_ptr_q, ret_ptr_q;
  logic                   alc_wrap_q, ret_wrap_q;
  logic [PTR_W:0]         cnt_q;

  logic [OITF_DEPTH-1:0]  vld_q;
  logic [OITF_DEPTH-1:0]  rdwen_q;
  logic [RFIDX_WIDTH-1:0] rdidx_q [OITF_DEPTH];
  logic [PC_SIZE-1:0]     pc_q    [OITF_DEPTH];

  logic ptr_eq;
  logic alc_fire, ret_fire;
  logic ret_vld;

  // Status: equal pointers are disambiguated by the wrap flags.
  assign ptr_eq     = (alc_ptr_q == ret_ptr_q);
  assign oitf_empty = ptr_eq & (alc_wrap_q == ret_wrap_q);
  assign oitf_full  = ptr_eq & (alc_wrap_q != ret_wrap_q);
  assign oitf_count = cnt_q;

  // Depends only on registered state and flush, never on dis_ena.
  assign dis_ready = ~oitf_full | flush;

  // Flush overrides both allocation and retirement.
  assign alc_fire = dis_ena & dis_ready & ~flush;
  assign ret_fire = ret_ena & ~oitf_empty & ~flush;

  assign dis_ptr = alc_ptr_q;
  assign ret_ptr = ret_ptr_q;

  // Oldest-entry view, masked by its valid bit so stale data after flush reads as zero.
  assign ret_vld   = vld_q[ret_ptr_q];
  assign ret_rdwen = ret_vld & rdwen_q[ret_ptr_q];
  assign ret_rdidx = {RFIDX_WIDTH{ret_vld}} & rdidx_q[ret_ptr_q];
  assign ret_pc    = {PC_SIZE{ret_vld}} & pc_q[ret_ptr_q];

  // Pointers, wrap flags and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alc_ptr_q  <= '0;
      ret_ptr_q  <= '0;
      alc_wrap_q <= 1'b0;
      ret_wrap_q <= 1'b0;
      cnt_q      <= '0;
    end else if (flush) begin
      alc_ptr_q  <= '0;
      ret_ptr_q  <= '0;
      alc_wrap_q <= 1'b0;
      ret_wrap_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (alc_fire) begin
        if (alc_ptr_q == LAST_IDX) begin
          alc_ptr_q  <= '0;
          alc_wrap_q <= ~alc_wrap_q;
        end else begin
          alc_ptr_q <= alc_ptr_q + PTR_W'(1);
        end
      end
      if (ret_fire) begin
        if (ret_ptr_q == LAST_IDX) begin
          ret_ptr_q  <= '0;
          ret_wrap_q <= ~ret_wrap_q;
        end else begin
          ret_ptr_q <= ret_ptr_q + PTR_W'(1);
        end
      end
      if (alc_fire && !ret_fire) begin
        cnt_q <= cnt_q + (PTR_W+1)'(1);
      end else if (ret_fire && !alc_fire) begin
        cnt_q <= cnt_q - (PTR_W+1)'(1);
      end
    end
  end

  // Entry storage. Allocate and retire can only hit the same slot when the
  // FIFO is full or empty, and in both cases one of them is blocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      rdwen_q <= '0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        rdidx_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < OITF_DEPTH; i++) begin
        if (alc_fire && (alc_ptr_q == PTR_W'(i))) begin
          vld_q[i]   <= 1'b1;
          rdwen_q[i] <= disp_i_rdwen;
          rdidx_q[i] <= disp_i_rdidx;
          pc_q[i]    <= disp_i_pc;
        end else if (ret_fire && (ret_ptr_q == PTR_W'(i))) begin
          vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // Hazard search over every valid writing entry. A retiring entry still
  // matches this cycle, which holds the dispatch stall for one extra cycle.
  always_comb begin
    logic hit_rs1, hit_rs2, hit_rd;
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (vld_q[i] && rdwen_q[i]) begin
        if (rdidx_q[i] == disp_i_rs1idx) hit_rs1 = 1'b1;
        if (rdidx_q[i] == disp_i_rs2idx) hit_rs2 = 1'b1;
        if (rdidx_q[i] == disp_i_rdidx)  hit_rd  = 1'b1;
      end
    end
    // x0 is never a real dependency.
    oitfrd_match_disprs1 = disp_i_rs1en & (disp_i_rs1idx != '0) & hit_rs1;
    oitfrd_match_disprs2 = disp_i_rs2en & (disp_i_rs2idx != '0) & hit_rs2;
    oitfrd_match_disprd  = disp_i_rdwen & (disp_i_rdidx  != '0) & hit_rd;
  end

endmodule

// File: tb/tb_exu_oitf_param.sv
module tb_exu_oitf_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        dis_ena, disp_i_rdwen, disp_i_rs1en, disp_i_rs2en, ret_ena, flush;
  logic [4:0]  disp_i_rdidx, disp_i_rs1idx, disp_i_rs2idx;
  logic [31:0] disp_i_pc;

  // DEPTH=4 instance
  logic        dis_ready, m_rs1, m_rs2, m_rd, ret_rdwen, oitf_empty, oitf_full;
  logic [1:0]  dis_ptr, ret_ptr;
  logic [4:0]  ret_rdidx;
  logic [31:0] ret_pc;
  logic [2:0]  oitf_count;

  // DEPTH=3 instance, same stimulus
  logic        dis_ready_3, m_rs1_3, m_rs2_3, m_rd_3, ret_rdwen_3, oitf_empty_3, oitf_full_3;
  logic [1:0]  dis_ptr_3, ret_ptr_3;
  logic [4:0]  ret_rdidx_3;
  logic [31:0] ret_pc_3;
  logic [2:0]  oitf_count_3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu_oitf_param #(.OITF_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .dis_ena(dis_ena), .dis_ready(dis_ready),
    .disp_i_rdwen(disp_i_rdwen), .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
    .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2), .oitfrd_match_disprd(m_rd),
    .dis_ptr(dis_ptr), .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdwen(ret_rdwen),
    .ret_rdidx(ret_rdidx), .ret_pc(ret_pc), .flush(flush),
    .oitf_empty(oitf_empty), .oitf_full(oitf_full), .oitf_count(oitf_count)
  );

  exu_oitf_param #(.OITF_DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .dis_ena(dis_ena), .dis_ready(dis_ready_3),
    .disp_i_rdwen(disp_i_rdwen), .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
    .oitfrd_match_disprs1(m_rs1_3), .oitfrd_match_disprs2(m_rs2_3), .oitfrd_match_disprd(m_rd_3),
    .dis_ptr(dis_ptr_3), .ret_ena(ret_ena), .ret_ptr(ret_ptr_3), .ret_rdwen(ret_rdwen_3),
    .ret_rdidx(ret_rdidx_3), .ret_pc(ret_pc_3), .flush(flush),
    .oitf_empty(oitf_empty_3), .oitf_full(oitf_full_3), .oitf_count(oitf_count_3)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic [31:0] pc, input logic wen);
    dis_ena      = 1'b1;
    disp_i_rdwen = wen;
    disp_i_rdidx = rd;
    disp_i_pc    = pc;
    tick();
    dis_ena      = 1'b0;
    disp_i_rdwen = 1'b0;
    disp_i_rdidx = '0;
  endtask

  task automatic retire();
    ret_ena = 1'b1;
    tick();
    ret_ena = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_empty"}, 64'(oitf_empty), 64'd1);
    check({tag, "_full"},  64'(oitf_full),  64'd0);
    check({tag, "_count"}, 64'(oitf_count), 64'd0);
    check({tag, "_rdy"},   64'(dis_ready),  64'd1);
    check({tag, "_disptr"}, 64'(dis_ptr),   64'd0);
    check({tag, "_retptr"}, 64'(ret_ptr),   64'd0);
    check({tag, "_retwen"}, 64'(ret_rdwen), 64'd0);
    check({tag, "_retrd"},  64'(ret_rdidx), 64'd0);
    check({tag, "_retpc"},  64'(ret_pc),    64'd0);
    check({tag, "_match"},  64'({m_rs1, m_rs2, m_rd}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    dis_ena = 0; disp_i_rdwen = 0; disp_i_rs1en = 0; disp_i_rs2en = 0;
    ret_ena = 0; flush = 0;
    disp_i_rdidx = 0; disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_pc = 0;

    // Reset then idle
    tick(); tick();
    check_idle("rst");
    rst = 1'b1;
    tick();
    check_idle("idle");

    // Fill 4 entries
    for (int n = 0; n < 4; n++) begin
      check("fill_disptr", 64'(dis_ptr), 64'(n));
      dispatch(5'(n + 1), 32'h8000_0000 + 32'(4 * n), 1'b1);
      check("fill_count", 64'(oitf_count), 64'(n + 1));
    end
    check("full_flag", 64'(oitf_full), 64'd1);
    check("full_rdy",  64'(dis_ready), 64'd0);

    // Dispatch while full is ignored
    dispatch(5'd9, 32'h1234, 1'b1);
    check("ovf_count",  64'(oitf_count), 64'd4);
    check("ovf_disptr", 64'(dis_ptr),    64'd0);
    check("ovf_retrd",  64'(ret_rdidx),  64'd1);

    // Retire in order
    for (int n = 0; n < 4; n++) begin
      check("ret_ptr",   64'(ret_ptr),   64'(n));
      check("ret_rdidx", 64'(ret_rdidx), 64'(n + 1));
      check("ret_pc",    64'(ret_pc),    64'(32'h8000_0000 + 32'(4 * n)));
      check("ret_rdwen", 64'(ret_rdwen), 64'd1);
      retire();
    end
    check("drain_empty", 64'(oitf_empty), 64'd1);
    check("drain_count", 64'(oitf_count), 64'd0);
    check("drain_retrd", 64'(ret_rdidx),  64'd0);

    // Hazards: rd=5 outstanding (slot 0)
    dispatch(5'd5, 32'h100, 1'b1);
    disp_i_rs1en = 1; disp_i_rs1idx = 5;
    disp_i_rs2en = 0; disp_i_rs2idx = 5;
    disp_i_rdwen = 1; disp_i_rdidx = 5;
    #1;
    check("raw_rs1",     64'(m_rs1), 64'd1);
    check("raw_rs2_off", 64'(m_rs2), 64'd0);
    check("waw_rd",      64'(m_rd),  64'd1);
    disp_i_rs2en = 1;
    #1;
    check("raw_rs2_on",  64'(m_rs2), 64'd1);
    disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rdwen = 0; disp_i_rdidx = 0;
    // rd=0 with rdwen (slot 1), rd=6 without rdwen (slot 2)
    dispatch(5'd0, 32'h104, 1'b1);
    dispatch(5'd6, 32'h108, 1'b0);
    disp_i_rs1en = 1; disp_i_rs1idx = 0;
    #1;
    check("x0_no_match", 64'(m_rs1), 64'd0);
    disp_i_rs1idx = 6;
    disp_i_rdwen = 1; disp_i_rdidx = 6;
    #1;
    check("nowen_rs1", 64'(m_rs1), 64'd0);
    check("nowen_rd",  64'(m_rd),  64'd0);
    disp_i_rdwen = 0; disp_i_rdidx = 0;
    // Retiring entry still matches in its retire cycle
    disp_i_rs1idx = 5;
    ret_ena = 1;
    #1;
    check("retiring_match", 64'(m_rs1), 64'd1);
    tick();
    ret_ena = 0;
    check("retired_nomatch", 64'(m_rs1), 64'd0);
    check("haz_count", 64'(oitf_count), 64'd2);
    disp_i_rs1en = 0; disp_i_rs1idx = 0;

    // Simultaneous alloc/retire at count=2: alc 3->0, ret 1->2
    check("sim2_disptr_pre", 64'(dis_ptr), 64'd3);
    check("sim2_retptr_pre", 64'(ret_ptr), 64'd1);
    ret_ena = 1;
    dispatch(5'd7, 32'h10C, 1'b1);
    ret_ena = 0;
    check("sim2_count",  64'(oitf_count), 64'd2);
    check("sim2_disptr", 64'(dis_ptr),    64'd0);
    check("sim2_retptr", 64'(ret_ptr),    64'd2);
    check("sim2_retrd",  64'(ret_rdidx),  64'd6);
    check("sim2_retwen", 64'(ret_rdwen),  64'd0);

    // Fill to full, then alloc+retire: only the retire happens
    dispatch(5'd8, 32'h110, 1'b1);
    dispatch(5'd9, 32'h114, 1'b1);
    check("sim4_full", 64'(oitf_full), 64'd1);
    check("sim4_rdy_pre", 64'(dis_ready), 64'd0);
    ret_ena = 1;
    dispatch(5'd10, 32'h118, 1'b1);
    ret_ena = 0;
    check("sim4_count",  64'(oitf_count), 64'd3);
    check("sim4_rdy",    64'(dis_ready),  64'd1);
    check("sim4_retptr", 64'(ret_ptr),    64'd3);
    check("sim4_retrd",  64'(ret_rdidx),  64'd7);
    check("sim4_disptr", 64'(dis_ptr),    64'd2);

    // Flush with dis_ena and ret_ena at count=3
    flush = 1; ret_ena = 1;
    #1;
    check("flush_rdy_pre", 64'(dis_ready), 64'd1);
    dispatch(5'd11, 32'h11C, 1'b1);
    flush = 0; ret_ena = 0;
    disp_i_rs1en = 1; disp_i_rs1idx = 7;
    #1;
    check_idle("flush");
    disp_i_rs1en = 0; disp_i_rs1idx = 0;

    // ret_ena while empty is ignored
    retire();
    check_idle("ret_empty");

    // Asynchronous reset mid-run at count=3
    dispatch(5'd1, 32'h200, 1'b1);
    dispatch(5'd2, 32'h204, 1'b1);
    dispatch(5'd3, 32'h208, 1'b1);
    disp_i_rs1en = 1; disp_i_rs1idx = 1;
    #1;
    check("mid_count_pre", 64'(oitf_count), 64'd3);
    check("mid_match_pre", 64'(m_rs1),      64'd1);
    #1;
    rst = 1'b0;
    #1;
    check_idle("midrst");
    disp_i_rs1en = 0; disp_i_rs1idx = 0;
    tick();
    rst = 1'b1;
    tick();

    // Wrap-around on DEPTH=3: seven dispatch/retire pairs
    for (int n = 0; n < 7; n++) begin
      dispatch(5'(n + 1), 32'h300 + 32'(4 * n), 1'b1);
      check("wrap_count", 64'(oitf_count_3), 64'd1);
      check("wrap_full",  64'(oitf_full_3),  64'd0);
      check("wrap_retptr", 64'(ret_ptr_3),   64'(n % 3));
      check("wrap_retrd", 64'(ret_rdidx_3),  64'(n + 1));
      retire();
      check("wrap_empty", 64'(oitf_empty_3), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
